// File: rtl/mdrp_responder.sv
// PLL-side responder for the 2-bit-opcode dynamic reconfiguration port.
// Byte register file with auto-incrementing pointer plus an emulated PLL lock.
module mdrp_responder #(
  parameter int ADDR_W       = 4,
  parameter int MULT_ADDR    = 3,
  parameter int MULT_DEFAULT = 37,
  parameter int LOCK_CYCLES  = 64
) (
  input  logic       mdclk,
  input  logic       rstn,
  input  logic       reset,
  input  logic [1:0] mdopc,
  input  logic       mdainc,
  input  logic [7:0] mdwdi,
  output logic [7:0] mdrdo,
  output logic       lock,
  output logic [7:0] mult
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [ADDR_W-1:0] MULT_IDX  = ADDR_W'(MULT_ADDR);
  localparam logic [7:0]        MULT_RST  = 8'(MULT_DEFAULT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    OPC_NOP   = 2'b00,
    OPC_WRITE = 2'b01,
    OPC_READ  = 2'b10,
    OPC_RSVD  = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  opcode_e           opc;
  logic              wr_en;
  logic              rd_en;
  logic              lock_loss;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        regs_q [DEPTH];
  logic [7:0]        mdrdo_q;
  logic [7:0]        mult_q;

  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign opc   = opcode_e'(mdopc);
  assign wr_en = (opc == OPC_WRITE);
  assign rd_en = (opc == OPC_READ);

  // mult_q mirrors regs_q[MULT_IDX], so it serves as the "current value" for
  // detecting a multiplier change without another read port.
  assign lock_loss = reset || (wr_en && (addr_q == MULT_IDX) && (mdwdi != mult_q));

  // Address pointer: every opcode, including NOP and reserved, honours mdainc.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge mdclk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
    end else if (mdainc) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // NOTE: the register file carries a full reset because reads of untouched
  // entries must return zero after rstn; this forces flops rather than RAM.
  always_ff @(posedge mdclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == MULT_ADDR) ? MULT_RST : 8'h00;
      end
      mult_q <= MULT_RST;
    end else if (wr_en) begin
      regs_q[addr_q] <= mdwdi;
      if (addr_q == MULT_IDX) begin
        mult_q <= mdwdi;
      end
    end
  end

  // Read data has one cycle of latency and holds on every non-READ cycle.
  always_ff @(posedge mdclk or negedge rstn) begin
    if (!rstn) begin
      mdrdo_q <= 8'h00;
    end else if (rd_en) begin
      mdrdo_q <= regs_q[addr_q];
    end
  end

  always_ff @(posedge mdclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock rises on the edge where cnt_q already equals LOCK_CYCLES-1, which
  // places it exactly LOCK_CYCLES edges after the last lock-loss cycle.
  // NOTE: defaults are assigned first so no path through the block leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (lock_loss) begin
      state_d = ST_UNLOCKED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOCKED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign mdrdo = mdrdo_q;
  assign mult  = mult_q;
  assign lock  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mdrp_responder.sv
// Scoreboard bench for mdrp_responder: READ expectations are queued by the
// stimulus and popped by a monitor when the read data appears.
module tb_mdrp_responder;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] READ  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic       mdclk = 1'b0;
  logic       rstn;
  logic       reset;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       lock;
  logic [7:0] mult;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       mon_rd;
  logic [7:0] mon_exp;

  mdrp_responder #(
    .ADDR_W      (4),
    .MULT_ADDR   (3),
    .MULT_DEFAULT(37),
    .LOCK_CYCLES (64)
  ) dut (
    .mdclk (mdclk),
    .rstn  (rstn),
    .reset (reset),
    .mdopc (mdopc),
    .mdainc(mdainc),
    .mdwdi (mdwdi),
    .mdrdo (mdrdo),
    .lock  (lock),
    .mult  (mult)
  );

  always #5 mdclk = ~mdclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one operation at a negedge and returns at the following negedge,
  // so outputs seen afterwards reflect this operation's clock edge.
  task automatic step(input logic [1:0] opc, input logic inc, input logic [7:0] wdi,
                      input logic [7:0] rd_exp = 8'h00);
    mdopc  = opc;
    mdainc = inc;
    mdwdi  = wdi;
    if (opc == READ) exp_q.push_back(rd_exp);
    @(negedge mdclk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, 1'b0, 8'h00);
  endtask

  // Monitor: a READ seen at a live clock edge produces data 1 ns later.
  always @(posedge mdclk) begin
    mon_rd = rstn && (mdopc == READ);
    #1;
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL mdrdo_unexpected: got %0h with no expected entry", mdrdo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("mdrdo", {24'h0, mdrdo}, {24'h0, mon_exp});
      end
    end
  end

  initial begin
    int k;
    rstn = 1'b0; reset = 1'b0; mdopc = NOP; mdainc = 1'b0; mdwdi = 8'h00;
    repeat (3) @(negedge mdclk);
    check("rst_mdrdo", {24'h0, mdrdo}, 32'h00);
    check("rst_lock",  {31'h0, lock},  32'h0);
    check("rst_mult",  {24'h0, mult},  32'd37);

    // Lock acquisition after rstn release.
    rstn = 1'b1;
    nops(63);
    check("lock_63",  {31'h0, lock}, 32'h0);
    check("mdrdo_63", {24'h0, mdrdo}, 32'h00);
    nops(1);
    check("lock_64",  {31'h0, lock}, 32'h1);
    check("mult_64",  {24'h0, mult}, 32'd37);

    // Pointer to 3, then reads with and without increment.
    for (int i = 0; i < 3; i++) step(NOP, 1'b1, 8'h00);
    step(READ, 1'b0, 8'h00, 8'd37);
    step(READ, 1'b1, 8'h00, 8'd37);
    step(READ, 1'b0, 8'h00, 8'd0);

    // Pointer 4 -> 3 by wrapping, then change the multiplier.
    for (int i = 0; i < 15; i++) step(NOP, 1'b1, 8'h00);
    step(WRITE, 1'b0, 8'd40);
    check("mult_40",      {24'h0, mult}, 32'd40);
    check("lock_drop_40", {31'h0, lock}, 32'h0);
    nops(63);
    check("lock_63_40",   {31'h0, lock}, 32'h0);
    nops(1);
    check("lock_64_40",   {31'h0, lock}, 32'h1);
    step(WRITE, 1'b0, 8'd40);
    check("lock_same_wr", {31'h0, lock}, 32'h1);
    nops(2);
    check("lock_same_wr2", {31'h0, lock}, 32'h1);

    // Reserved opcode: no write, read data holds, only increment applies.
    step(READ, 1'b0, 8'h00, 8'd40);
    step(RSVD, 1'b0, 8'hAA);
    check("rsvd_mdrdo", {24'h0, mdrdo}, 32'd40);
    check("rsvd_mult",  {24'h0, mult},  32'd40);
    check("rsvd_lock",  {31'h0, lock},  32'h1);
    step(RSVD, 1'b1, 8'hAA);
    for (int i = 0; i < 12; i++) step(NOP, 1'b1, 8'h00);

    // Burst write / read with wrap.
    for (int i = 0; i < 16; i++) begin
      step(WRITE, 1'b1, 8'h10 + 8'(i));
      if (i == 3) check("burst_lock_drop", {31'h0, lock}, 32'h0);
    end
    check("burst_mult", {24'h0, mult}, 32'h13);
    for (int i = 0; i < 16; i++) step(READ, 1'b1, 8'h00, 8'h10 + 8'(i));
    step(READ, 1'b0, 8'h00, 8'h10);
    check("burst_lock_still0", {31'h0, lock}, 32'h0);
    k = 0;
    while (!lock && k < 200) begin
      nops(1);
      k++;
    end
    check("burst_relock", {31'h0, lock}, 32'h1);

    // Reset request with a simultaneous write to the multiplier register.
    for (int i = 0; i < 3; i++) step(NOP, 1'b1, 8'h00);
    reset = 1'b1;
    step(WRITE, 1'b0, 8'h55);
    check("rstreq_lock", {31'h0, lock}, 32'h0);
    check("rstreq_mult", {24'h0, mult}, 32'h55);
    nops(9);
    check("rstreq_hold_lock", {31'h0, lock}, 32'h0);
    reset = 1'b0;
    nops(63);
    check("rstreq_lock_63", {31'h0, lock}, 32'h0);
    nops(1);
    check("rstreq_lock_64", {31'h0, lock}, 32'h1);
    step(READ, 1'b1, 8'h00, 8'h55);

    // rstn mid-burst, with a READ in flight that must be discarded.
    step(WRITE, 1'b1, 8'hA0);
    step(WRITE, 1'b1, 8'hA1);
    mdopc = READ; mdainc = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("arst_mdrdo", {24'h0, mdrdo}, 32'h00);
    check("arst_mult",  {24'h0, mult},  32'd37);
    check("arst_lock",  {31'h0, lock},  32'h0);
    @(negedge mdclk);
    mdopc = NOP; mdainc = 1'b0;
    @(negedge mdclk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(NOP, 1'b1, 8'h00);
    step(READ, 1'b1, 8'h00, 8'd37);
    step(READ, 1'b0, 8'h00, 8'h00);
    nops(20);
    check("arst_counting_lock", {31'h0, lock}, 32'h0);

    // rstn during counting restarts the full lock delay.
    rstn = 1'b0;
    @(negedge mdclk);
    rstn = 1'b1;
    nops(63);
    check("arst2_lock_63", {31'h0, lock}, 32'h0);
    nops(1);
    check("arst2_lock_64", {31'h0, lock}, 32'h1);

    nops(2);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
